// File: rtl/filtered_synchronizer_pkg.sv
// Shared helpers for the filtered synchronizer slice.
// Sizes the per-channel glitch-filter counter.
`timescale 1ns/100ps
package filtered_synchronizer_pkg;

    // Counter must hold 0..cycles-1; never narrower than one bit
    function automatic int unsigned filter_cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/fast_synchronizer.sv
// Plain multi-flop synchronizer for one asynchronous bit.
// The first flop samples d_i; q_o is the last stage.
`timescale 1ns/100ps
module fast_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/filtered_synchronizer.sv
// Per-channel synchronizer with optional persistence filter and
// registered-copy edge detection.
`timescale 1ns/100ps
module filtered_synchronizer
    import filtered_synchronizer_pkg::*;
#(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned STAGES        = 2,
    parameter int unsigned FILTER_CYCLES = 0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rising_edge,
    output logic [WIDTH-1:0] falling_edge
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic sync_s;
        logic level;
        logic level_q;

        fast_synchronizer #(
            .STAGES(STAGES)
        ) u_sync (
            .clock (clock),
            .resetn(resetn),
            .d_i   (data_in[i]),
            .q_o   (sync_s)
        );

        if (FILTER_CYCLES == 0) begin : g_bypass
            assign level = sync_s;
        end else begin : g_filter
            localparam int unsigned       CNT_W    = filter_cnt_width(FILTER_CYCLES);
            localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             out_q;
            logic             out_d;

            // Any cycle where s agrees with the output restarts the count
            always_comb begin
                cnt_d = '0;
                out_d = out_q;
                if (sync_s != out_q) begin
                    if (cnt_q == CNT_LAST) begin
                        out_d = sync_s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    cnt_q <= '0;
                    out_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    out_q <= out_d;
                end
            end

            assign level = out_q;
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                level_q <= 1'b0;
            end else begin
                level_q <= level;
            end
        end

        assign data_out[i]     = level;
        assign rising_edge[i]  = level & ~level_q;
        assign falling_edge[i] = ~level & level_q;
    end

endmodule

// File: doc/filtered_synchronizer.md
FILTERED_SYNCHRONIZER -- requirements
Module: filtered_synchronizer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent channels (≥1).
REQ-002 The block SHALL have parameter STAGES, default 2, giving the number of synchronizer flops per channel (≥1).
REQ-003 The block SHALL have parameter FILTER_CYCLES, default 0, giving the number of consecutive cycles a new synchronized value must hold before it is accepted; 0 disables the filter.
REQ-004 The block SHALL have port clock, input, width 1: single clock for all logic.
REQ-005 The block SHALL have port resetn, input, width 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port data_in, input, width WIDTH: asynchronous input bits.
REQ-007 The block SHALL have port data_out, output, width WIDTH: synchronized, filtered level.
REQ-008 The block SHALL have port rising_edge, output, width WIDTH: one-cycle pulse on each data_out 0→1 transition.
REQ-009 The block SHALL have port falling_edge, output, width WIDTH: one-cycle pulse on each data_out 1→0 transition.

Function
REQ-010 Each channel SHALL be processed independently; no cross-channel coherency is guaranteed.
REQ-011 Synchronizer stage: a data_in bit stable across posedge N SHALL appear on the internal synchronized value s after posedge N+STAGES-1.
REQ-012 FILTER_CYCLES=0: data_out SHALL equal s directly, with no added latency.
REQ-013 FILTER_CYCLES=F≥1: each channel SHALL hold a counter of width $clog2(F+1), reset to 0.
REQ-014 Per clock, if s==data_out, the counter SHALL clear to 0.
REQ-015 Per clock, if s!=data_out and counter<F-1, the counter SHALL increment by 1.
REQ-016 Per clock, if s!=data_out and counter==F-1, data_out SHALL take s and the counter SHALL clear to 0.
REQ-017 The counter SHALL never exceed F-1; no wrap-around is possible.
REQ-018 Resulting latency: a change of data_in stable across posedge N SHALL appear on data_out after posedge N+STAGES-1+F.
REQ-019 A synchronized pulse or glitch lasting fewer than F cycles SHALL NOT change data_out and SHALL NOT produce edge pulses.
REQ-020 A signal toggling back to the current data_out value mid-count SHALL restart filtering from 0.
REQ-021 rising_edge[i] SHALL be high exactly during the first cycle data_out[i] is 1 after being 0; likewise falling_edge[i] for 1 after 0 reversed.
REQ-022 Edge pulses SHALL be derived from a registered copy of data_out; rising_edge and falling_edge SHALL never be high simultaneously on one channel.

Reset
REQ-023 While resetn=0, all synchronizer flops, counters, data_out and the registered copy SHALL be 0 immediately (asynchronously).
REQ-024 While resetn=0 and in the first cycle after release, rising_edge and falling_edge SHALL be 0.
REQ-025 Reset asserted mid-filtering SHALL discard the pending count; no deferred update is allowed.

Structure
REQ-026 No shared package is required; counter width SHALL be a local parameter.
REQ-027 Each channel SHALL instantiate the existing fast_synchronizer (STAGES passed through) as its only sub-module; filter and edge logic SHALL sit in a per-channel generate loop.

Verification
REQ-028 Bench configurations SHALL be WIDTH=4 with STAGES in {1,2,3} and FILTER_CYCLES in {0,1,3}, clock period 10 ns.
REQ-029 Latency check (STAGES=2, F=3): data_in[0] rises 2.5 ns after posedge 0 -> data_out[0]=1 after posedge 5; rising_edge[0]=1 only between posedges 5 and 6.
REQ-030 Glitch rejection (STAGES=2, F=3): data_in[1] high for exactly 2 cycles -> data_out[1] stays 0; rising_edge[1] and falling_edge[1] stay 0.
REQ-031 Bypass check (STAGES=3, F=0): data_in[2] falls 7.5 ns after posedge N -> data_out[2]=0 after posedge N+3; falling_edge[2] pulses for exactly one cycle.
REQ-032 Independent channels: data_in=4'b0011 then 4'b1100 set in the same cycle -> bits 0,1 fall and bits 2,3 rise on the same edge; matching falling_edge/rising_edge pulses appear on the correct bits.
REQ-033 Reset mid-operation: resetn driven low while a channel counter is at 2 (F=3) -> all outputs 0 at once; after release with data_in=0, no edge pulses occur and data_out stays 0.
